// File: rtl/activation_unit.sv
// Two-stage pipelined lane-wise activation (bypass / ReLU / leaky ReLU / clamped ReLU)
// with valid/ready backpressure and a saturating count of zeroed lanes.
module activation_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int SA_LENGTH  = 3,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data [SA_LENGTH],
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] clamp_max,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data [SA_LENGTH],
  output logic [CNT_WIDTH-1:0]         zero_count,
  input  logic                         cnt_clear
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_RELU   = 2'b01,
    MODE_LEAKY  = 2'b10,
    MODE_CLAMP  = 2'b11
  } act_mode_t;

  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_data [SA_LENGTH];
  act_mode_t                    s1_mode;
  logic signed [DATA_WIDTH-1:0] s1_clamp;

  logic                         s1_adv;
  logic                         s2_adv;
  logic signed [DATA_WIDTH-1:0] clamp_c;
  logic signed [DATA_WIDTH-1:0] act [SA_LENGTH];
  logic [CNT_WIDTH:0]           zero_inc;
  logic [CNT_WIDTH:0]           cnt_sum;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_BYPASS;
      s1_clamp <= '0;
      for (int unsigned i = 0; i < SA_LENGTH; i++) s1_data[i] <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode  <= act_mode_t'(mode);
        s1_clamp <= clamp_max;
        for (int unsigned i = 0; i < SA_LENGTH; i++) s1_data[i] <= in_data[i];
      end
    end
  end

  // Lane math stays at DATA_WIDTH; sign bit tests avoid widened compares against 0.
  always_comb begin
    clamp_c  = s1_clamp[DATA_WIDTH-1] ? '0 : s1_clamp;
    zero_inc = '0;
    for (int unsigned i = 0; i < SA_LENGTH; i++) begin
      act[i] = s1_data[i];
      unique case (s1_mode)
        MODE_RELU:  if (s1_data[i][DATA_WIDTH-1]) act[i] = '0;
        MODE_LEAKY: if (s1_data[i][DATA_WIDTH-1]) act[i] = s1_data[i] >>> LEAK_SHIFT;
        MODE_CLAMP: begin
          if (s1_data[i][DATA_WIDTH-1]) act[i] = '0;
          else if (s1_data[i] > clamp_c) act[i] = clamp_c;
        end
        default: act[i] = s1_data[i];
      endcase
      if ((s1_mode == MODE_RELU || s1_mode == MODE_CLAMP) &&
          (s1_data[i][DATA_WIDTH-1] || s1_data[i] == '0))
        zero_inc = zero_inc + {{CNT_WIDTH{1'b0}}, 1'b1};
    end
    cnt_sum = {1'b0, zero_count} + zero_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < SA_LENGTH; i++) out_data[i] <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid)
        for (int unsigned i = 0; i < SA_LENGTH; i++) out_data[i] <= act[i];
    end
  end

  // Clear wins over the increment of the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      zero_count <= '0;
    else if (cnt_clear)
      zero_count <= '0;
    else if (s2_adv && s1_valid)
      zero_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: directed beats, queue of expected outputs, separate monitor.
`timescale 1ns/1ps
module tb_activation_unit;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready, in_ready_s;
  logic signed [7:0] in_data [3];
  logic [1:0]        mode;
  logic signed [7:0] clamp_max;
  logic              out_valid, out_valid_s;
  logic              out_ready;
  logic signed [7:0] out_data [3];
  logic signed [7:0] out_data_s [3];
  logic [15:0]       zero_count;
  logic [3:0]        zero_count_s;
  logic              cnt_clear;
  logic [23:0]       out_flat, out_flat_s, held;
  bit                prev_stall;
  bit                stall_seen;

  typedef struct packed {
    logic [23:0] d;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt, exp_cnt_s;

  always #5 clk = ~clk;

  assign out_flat   = {out_data[2], out_data[1], out_data[0]};
  assign out_flat_s = {out_data_s[2], out_data_s[1], out_data_s[0]};

  activation_unit #(.DATA_WIDTH(8), .SA_LENGTH(3), .LEAK_SHIFT(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .clamp_max(clamp_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .zero_count(zero_count), .cnt_clear(cnt_clear)
  );

  activation_unit #(.DATA_WIDTH(8), .SA_LENGTH(3), .LEAK_SHIFT(3), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .mode(mode), .clamp_max(clamp_max),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .zero_count(zero_count_s), .cnt_clear(cnt_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int a, input int b, input int c, input logic [1:0] m, input int cm,
                      input int e0, input int e1, input int e2, input int nz, input bit clr);
    bit    acc = 0;
    item_t it;
    in_data[0] = a[7:0];
    in_data[1] = b[7:0];
    in_data[2] = c[7:0];
    mode       = m;
    clamp_max  = cm[7:0];
    in_valid   = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (in_ready && in_ready_s) acc = 1;
      else stall_seen = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      if (clr) begin
        exp_cnt   = 0;
        exp_cnt_s = 0;
      end else begin
        exp_cnt   = (exp_cnt + nz > 65535) ? 65535 : exp_cnt + nz;
        exp_cnt_s = (exp_cnt_s + nz > 15) ? 15 : exp_cnt_s + nz;
      end
      it.d     = {e2[7:0], e1[7:0], e0[7:0]};
      it.cnt   = exp_cnt[15:0];
      it.cnt_s = exp_cnt_s[3:0];
      sb.push_back(it);
      if (clr) begin
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  // Monitor: pop on every handshake, and check that a stalled beat holds still.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {8'd0, out_flat}, {8'd0, held});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
          else begin
            it = sb.pop_front();
            chk("out_data", {8'd0, out_flat}, {8'd0, it.d});
            chk("zero_count", {16'd0, zero_count}, {16'd0, it.cnt});
            chk("sat_valid", {31'd0, out_valid_s}, 32'd1);
            chk("sat_data", {8'd0, out_flat_s}, {8'd0, it.d});
            chk("sat_count", {28'd0, zero_count_s}, {28'd0, it.cnt_s});
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = out_flat;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; clamp_max = '0;
    out_ready = 1'b1; cnt_clear = 1'b0; in_data = '{default: '0};
    exp_cnt = 0; exp_cnt_s = 0; stall_seen = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {8'd0, out_flat}, 32'd0);
    chk("rst_zero_count", {16'd0, zero_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ReLU, with latency check
    send(5, -100, 127, 2'b01, 0, 5, 0, 127, 1, 0);
    chk("lat_stage1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_stage2", {31'd0, out_valid}, 32'd1);
    chk("zc_relu", {16'd0, zero_count}, 32'd1);

    // Leaky ReLU, flooring shift
    send(-100, -1, 64, 2'b10, 0, -13, -1, 64, 0, 0);
    send(-128, -8, -7, 2'b10, 0, -16, -1, -1, 0, 0);
    // Clamped ReLU, including negative and zero ceilings
    send(-10, 15, 120, 2'b11, 20, 0, 15, 20, 1, 0);
    send(30, 0, -3, 2'b11, -5, 0, 0, 0, 2, 0);
    send(5, -5, 0, 2'b11, 0, 0, 0, 0, 2, 0);
    // Bypass extremes
    send(-128, 127, 0, 2'b00, 0, -128, 127, 0, 0, 0);
    wait_drain();

    // Six back-to-back beats with a downstream stall
    stall_seen = 0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(10, 20, 30, 2'b00, 0, 10, 20, 30, 0, 0);
    send(-1, -2, -3, 2'b00, 0, -1, -2, -3, 0, 0);
    send(7, 8, 9, 2'b00, 0, 7, 8, 9, 0, 0);
    send(-128, 0, 127, 2'b00, 0, -128, 0, 127, 0, 0);
    send(1, 1, 1, 2'b00, 0, 1, 1, 1, 0, 0);
    send(2, 2, 2, 2'b00, 0, 2, 2, 2, 0, 0);
    chk("in_ready_dropped", {31'd0, stall_seen}, 32'd1);
    wait_drain();

    // Drive the 4-bit counter to 14, then past saturation
    send(-1, -2, -3, 2'b01, 0, 0, 0, 0, 3, 0);
    send(-1, -2, -3, 2'b01, 0, 0, 0, 0, 3, 0);
    send(-1, -1, 5, 2'b01, 0, 0, 0, 5, 2, 0);
    send(-4, 0, -9, 2'b01, 0, 0, 0, 0, 3, 0);
    wait_drain();
    chk("sat_hold", {28'd0, zero_count_s}, 32'd15);
    // Clear coinciding with an increment
    send(0, -5, 9, 2'b01, 0, 0, 0, 9, 2, 1);
    send(-1, 2, 3, 2'b01, 0, 0, 2, 3, 1, 0);
    wait_drain();

    // Fill both stages, then reset asynchronously
    out_ready = 1'b0;
    send(11, 12, 13, 2'b00, 0, 11, 12, 13, 0, 0);
    send(-6, -7, 8, 2'b01, 0, 0, 0, 8, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {8'd0, out_flat}, 32'd0);
    chk("arst_zero_count", {16'd0, zero_count}, 32'd0);
    sb.delete();
    exp_cnt = 0; exp_cnt_s = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(-4, 4, 0, 2'b01, 0, 0, 4, 0, 2, 0);
    chk("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_lat2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
